// File: rtl/smi_mdio_master_if.sv
// Host-side request/response and MDIO pad signals of the SMI master.
interface smi_mdio_master_if;
   logic        smi_wract;
   logic        smi_rdact;
   logic [15:0] smi_wdata;
   logic [4:0]  smi_phy_addr;
   logic [4:0]  smi_dev_addr;
   logic [15:0] smi_rdata;
   logic        smi_rdval;
   logic        operate_busy;
   logic        smi_mdc;
   logic        smi_mdo;
   logic        smi_link;
   logic        smi_mdi;

   modport master (
      input  smi_wract, smi_rdact, smi_wdata, smi_phy_addr, smi_dev_addr, smi_mdi,
      output smi_rdata, smi_rdval, operate_busy, smi_mdc, smi_mdo, smi_link
   );

   modport slave (
      output smi_wract, smi_rdact, smi_wdata, smi_phy_addr, smi_dev_addr, smi_mdi,
      input  smi_rdata, smi_rdval, operate_busy, smi_mdc, smi_mdo, smi_link
   );
endinterface

// File: rtl/smi_mdio_master.sv
// Clause 22 MDIO/SMI master. Define SMI_PREAMBLE_EN to send the 32-bit preamble;
// without it frames start directly with ST and are 32 bits long.
module smi_mdio_master #(
   parameter int unsigned MDC_DIV = 20
) (
   input  logic               clk_100m,
   input  logic               rst_100m,
   smi_mdio_master_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
`ifdef SMI_PREAMBLE_EN
      S_PRE,
`endif
      S_HDR,
      S_TA,
      S_DATA,
      S_DONE
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(MDC_DIV - 1);

   state_t      state_q, state_d;
   logic [5:0]  bit_q, bit_d;
   logic [7:0]  div_q, div_d;
   logic        half_q, half_d;
   logic        wr_q, wr_d;
   logic [31:0] tx_q, tx_d;
   logic [15:0] rx_q, rx_d;
   logic [15:0] rdata_q, rdata_d;

   logic in_frame;
   logic in_pre;
   logic bit_end;

`ifdef SMI_PREAMBLE_EN
   assign in_pre   = (state_q == S_PRE);
`else
   assign in_pre   = 1'b0;
`endif
   assign in_frame = in_pre || (state_q == S_HDR) || (state_q == S_TA) || (state_q == S_DATA);
   // A bit ends on the last cycle of its high (second) half.
   assign bit_end  = half_q && (div_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      div_d   = div_q;
      half_d  = half_q;
      wr_d    = wr_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (bus.smi_wract || bus.smi_rdact) begin
               wr_d = bus.smi_wract;
               tx_d = bus.smi_wract
                  ? {2'b01, 2'b01, bus.smi_phy_addr, bus.smi_dev_addr, 2'b10, bus.smi_wdata}
                  : {2'b01, 2'b10, bus.smi_phy_addr, bus.smi_dev_addr, 18'h3FFFF};
`ifdef SMI_PREAMBLE_EN
               state_d = S_PRE;
`else
               state_d = S_HDR;
`endif
            end
         end
`ifdef SMI_PREAMBLE_EN
         S_PRE:  if (bit_end && bit_q == 6'd31) state_d = S_HDR;
`endif
         S_HDR:  if (bit_end && bit_q == 6'd13) state_d = S_TA;
         S_TA:   if (bit_end && bit_q == 6'd1)  state_d = S_DATA;
         S_DATA: begin
            if (bit_end && bit_q == 6'd15) begin
               state_d = S_DONE;
               if (!wr_q) rdata_d = rx_q;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) begin
         bit_d  = '0;
         div_d  = '0;
         half_d = 1'b0;
      end else if (in_frame) begin
         if (div_q == DIV_LAST) begin
            div_d  = '0;
            half_d = !half_q;
            if (half_q) bit_d = bit_q + 6'd1;
         end else begin
            div_d = div_q + 8'd1;
         end
      end

      // The frame word only advances once the preamble is behind us.
      if (in_frame && !in_pre && bit_end) tx_d = {tx_q[30:0], 1'b1};

      if (state_q == S_DATA && half_q && div_q == '0) rx_d = {rx_q[14:0], bus.smi_mdi};
   end

   always_ff @(posedge clk_100m or posedge rst_100m) begin
      if (rst_100m) begin
         state_q <= S_IDLE;
         bit_q   <= '0;
         div_q   <= '0;
         half_q  <= 1'b0;
         wr_q    <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         half_q  <= half_d;
         wr_q    <= wr_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.operate_busy = in_frame;
   assign bus.smi_mdc      = in_frame && half_q;
   assign bus.smi_mdo      = (in_frame && !in_pre) ? tx_q[31] : 1'b1;
   assign bus.smi_link     = in_pre || (state_q == S_HDR) ||
                             (((state_q == S_TA) || (state_q == S_DATA)) && wr_q);
   assign bus.smi_rdval    = (state_q == S_DONE) && !wr_q;
   assign bus.smi_rdata    = rdata_q;

endmodule

// File: doc/smi_mdio_master.md
SMI_MDIO_MASTER -- requirements
Module: smi_mdio_master

Interface
REQ-001 Parameter MDC_DIV, default 20, clk_100m cycles per MDC half-period (MDC = 2.5 MHz at 100 MHz); legal range 2..255.
REQ-002 clk_100m  input  1  system clock; all logic on its rising edge.
REQ-003 rst_100m  input  1  asynchronous, active-high reset.
REQ-004 smi_wract  input  1  one-cycle write request.
REQ-005 smi_rdact  input  1  one-cycle read request.
REQ-006 smi_wdata  input  16  write data, sampled on accept.
REQ-007 smi_phy_addr  input  5  PHY address, sampled on accept.
REQ-008 smi_dev_addr  input  5  register address, sampled on accept.
REQ-009 smi_rdata  output  16  read data, valid while smi_rdval is high.
REQ-010 smi_rdval  output  1  one-cycle read-complete strobe.
REQ-011 operate_busy  output  1  frame in progress.
REQ-012 smi_mdc  output  1  management clock.
REQ-013 smi_mdo  output  1  serial data out.
REQ-014 smi_link  output  1  MDIO output enable (1 = drive smi_mdo onto the pad).
REQ-015 smi_mdi  input  1  serial data in; sampled unsynchronised, because MDC is slow relative to clk_100m.

Function
REQ-016 Accept: request accepted when operate_busy=0; operate_busy=1 from the next cycle.
REQ-017 Requests arriving while operate_busy=1 are ignored and are not queued.
REQ-018 smi_wract and smi_rdact high in the same cycle: the request is treated as a write.
REQ-019 Frame (Clause 22), in bit order: preamble (32 ones), ST=01, OP (01 write / 10 read), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0], all MSB first.
REQ-020 TA bits: write drives 1,0; read sets smi_link=0 for both TA bits and for DATA.
REQ-021 Bit timing: each bit lasts 2*MDC_DIV cycles; smi_mdc is low for the first MDC_DIV cycles of the bit and high for the second.
REQ-022 smi_mdo/smi_link change only at bit start (MDC falling edge); smi_mdi is sampled in the cycle smi_mdc goes high.
REQ-023 State machine: IDLE -> PRE (32 bits) -> HDR (ST, OP, PHYAD, REGAD: 14 bits) -> TA (2 bits) -> DATA (16 bits) -> DONE (1 cycle) -> IDLE.
REQ-024 MDC must not toggle in IDLE; smi_mdc=0, smi_mdo=1, smi_link=0 there.
REQ-025 Counters: a bit counter of 6 bits and a divider counter of 8 bits; both clear on entry to every state.
REQ-026 In DONE, operate_busy falls; a read also pulses smi_rdval for exactly that cycle.
REQ-027 smi_rdata holds the last read value until the next read completes; it is unchanged by writes.
REQ-028 Write latency: accept to operate_busy low = 64*2*MDC_DIV+2 cycles (32-bit preamble); a read has identical latency.
REQ-029 A new request is accepted in the first IDLE cycle after DONE (back-to-back operation).

Reset
REQ-030 On rst_100m=1, immediately and mid-frame: state=IDLE, operate_busy=0, smi_rdval=0, smi_rdata=0, smi_mdc=0, smi_mdo=1, smi_link=0, counters=0.
REQ-031 A frame aborted by reset is not resumed; no smi_rdval is produced for it.

Configuration
REQ-032 Macro SMI_PREAMBLE_EN defined: the 32-bit preamble is sent (PRE state present).
REQ-033 SMI_PREAMBLE_EN undefined: PRE state is removed; IDLE goes directly to HDR; frame = 32 bits; latency = 32*2*MDC_DIV+2 cycles.

Verification
REQ-034 Write: phy 1, reg 0x12, data 0x80F0 -> decoded smi_mdo stream 32x1, 01, 01, 00001, 10010, 10, 1000000011110000; smi_link=1 throughout; operate_busy low after 64*2*MDC_DIV+2 cycles.
REQ-035 Read: phy 2, reg 0x1F; MDI model drives 0x0003 -> smi_link=0 from TA start; one smi_rdval pulse with smi_rdata=0x0003.
REQ-036 smi_rdact issued 10 cycles into a write frame -> ignored; only the write frame appears and no smi_rdval pulse occurs.
REQ-037 smi_wract and smi_rdact in the same cycle -> write frame with OP=01 and no smi_rdval.
REQ-038 rst_100m asserted during DATA of a read -> all outputs take their reset values asynchronously; no smi_rdval; the next request yields a normal frame.
REQ-039 Build without SMI_PREAMBLE_EN -> the same write as REQ-034 begins with 01 on the first MDC edge and completes in 32*2*MDC_DIV+2 cycles.
